// File: rtl/k12a_input_conditioner_pkg.sv
// Shared types and helpers for the k12a input conditioner.
package k12a_input_conditioner_pkg;

    // Global wake FSM: waits for the core to halt, then clears flags when it resumes.
    typedef enum logic {
        ICOND_ARMED     = 1'b0,
        ICOND_HALT_SEEN = 1'b1
    } icond_state_t;

    // Width of the core's gpio_in / wake_sources buses.
    localparam int ICOND_CORE_WIDTH = 8;

    // An accepted edge qualifies for wake when the new level matches the selected polarity
    // (rise_sel = 1 selects rising edges, 0 selects falling edges).
    function automatic logic wake_qual(input logic accept, input logic new_level, input logic rise_sel);
        return accept & (new_level == rise_sel);
    endfunction

endpackage

// File: rtl/k12a_debounce_chan.sv
// One input channel: 2-flop synchroniser, debounce counter and one-cycle edge pulse.
module k12a_debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic cpu_clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic edge_pulse,
    output logic level_next,
    output logic accept_next
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             pulse_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Synchroniser chain; only sync2 is allowed to influence the debounce logic.
    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Count consecutive cycles of disagreement; accept on the last one so the counter never wraps.
    always_comb begin
        cnt_next    = cnt_reg;
        level_next  = level_reg;
        accept_next = 1'b0;
        if (sync2_reg == level_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_next    = '0;
            level_next  = sync2_reg;
            accept_next = 1'b1;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Debounce state registers; a reset mid-count discards the partial count.
    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            pulse_reg <= accept_next;
        end
    end

    assign level      = level_reg;
    assign edge_pulse = pulse_reg;

endmodule

// File: rtl/k12a_input_conditioner.sv
// Conditions raw board inputs into debounced levels and sticky wake flags for the k12a core.
module k12a_input_conditioner
    import k12a_input_conditioner_pkg::*;
#(
    parameter int               WIDTH           = ICOND_CORE_WIDTH,
    parameter int               DEBOUNCE_CYCLES = 1000,
    parameter logic [WIDTH-1:0] WAKE_RISE_MASK  = '1
) (
    input  logic             cpu_clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             halted,
    output logic [WIDTH-1:0] levels,
    output logic [WIDTH-1:0] wake_sources,
    output logic [WIDTH-1:0] edge_pulse
);

    icond_state_t     state_reg;
    icond_state_t     state_next;
    logic             clear_next;
    logic [WIDTH-1:0] level_next;
    logic [WIDTH-1:0] accept_next;
    logic [WIDTH-1:0] qual;
    logic [WIDTH-1:0] wake_reg;
    logic [WIDTH-1:0] wake_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            k12a_debounce_chan #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_chan (
                .cpu_clock  (cpu_clock),
                .reset      (reset),
                .raw        (raw_in[gi]),
                .level      (levels[gi]),
                .edge_pulse (edge_pulse[gi]),
                .level_next (level_next[gi]),
                .accept_next(accept_next[gi])
            );

            // Qualify from the same-cycle update so the flag sets on the edge the level changes.
            assign qual[gi] = wake_qual(accept_next[gi], level_next[gi], WAKE_RISE_MASK[gi]);
        end
    endgenerate

    // Wake FSM state register.
    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            state_reg <= ICOND_ARMED;
        end else begin
            state_reg <= state_next;
        end
    end

    // Leaving halt clears all flags; new qualifying edges in that cycle still set (set beats clear).
    always_comb begin
        state_next = state_reg;
        clear_next = 1'b0;
        case (state_reg)
            ICOND_ARMED: begin
                if (halted) begin
                    state_next = ICOND_HALT_SEEN;
                end
            end
            ICOND_HALT_SEEN: begin
                if (!halted) begin
                    state_next = ICOND_ARMED;
                    clear_next = 1'b1;
                end
            end
            default: begin
                state_next = ICOND_ARMED;
            end
        endcase
        wake_next = (clear_next ? '0 : wake_reg) | qual;
    end

    // Sticky wake flag register.
    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            wake_reg <= '0;
        end else begin
            wake_reg <= wake_next;
        end
    end

    assign wake_sources = wake_reg;

endmodule

// File: tb/tb_k12a_input_conditioner.sv
// Directed bench for k12a_input_conditioner with DEBOUNCE_CYCLES=4.
// Two instances share inputs: dut uses all-rising wake polarity, dut_fd makes channel 1 falling-edge.
module tb_k12a_input_conditioner;

    localparam int W = 8;
    localparam int D = 4;

    logic         cpu_clock;
    logic         reset;
    logic [W-1:0] raw_in;
    logic         halted;
    logic [W-1:0] levels, wake_sources, edge_pulse;
    logic [W-1:0] levels_fd, wake_fd, edge_fd;

    int checks = 0;
    int errors = 0;

    k12a_input_conditioner #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .WAKE_RISE_MASK(8'hFF)
    ) dut (
        .cpu_clock   (cpu_clock),
        .reset       (reset),
        .raw_in      (raw_in),
        .halted      (halted),
        .levels      (levels),
        .wake_sources(wake_sources),
        .edge_pulse  (edge_pulse)
    );

    k12a_input_conditioner #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .WAKE_RISE_MASK(8'hFD)
    ) dut_fd (
        .cpu_clock   (cpu_clock),
        .reset       (reset),
        .raw_in      (raw_in),
        .halted      (halted),
        .levels      (levels_fd),
        .wake_sources(wake_fd),
        .edge_pulse  (edge_fd)
    );

    initial cpu_clock = 1'b0;
    always #5 cpu_clock = ~cpu_clock;

    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] lv;
        logic [W-1:0] ep;
        logic [W-1:0] wk;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge cpu_clock);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        // Glitch rows: sync2 differs for 3 edges, gap, again 3 edges; never accepted (D=4).
        for (int i = 0; i < 13; i++) begin
            vecs[i].raw = ((i < 3) || (i >= 6 && i < 9)) ? 8'h01 : 8'h00;
            vecs[i].lv  = 8'h00;
            vecs[i].ep  = 8'h00;
            vecs[i].wk  = 8'h00;
        end
        // Held rising edge on channel 0: accepted on the 6th edge after driving.
        for (int i = 0; i < 7; i++) begin
            vecs[13+i].raw = 8'h01;
            vecs[13+i].lv  = (i >= 5) ? 8'h01 : 8'h00;
            vecs[13+i].ep  = (i == 5) ? 8'h01 : 8'h00;
            vecs[13+i].wk  = (i >= 5) ? 8'h01 : 8'h00;
        end

        reset  = 1'b1;
        raw_in = '0;
        halted = 1'b0;
        tick(2);
        chk("reset_levels", levels, 8'h00);
        chk("reset_edge", edge_pulse, 8'h00);
        chk("reset_wake", wake_sources, 8'h00);
        reset = 1'b0;

        for (int v = 0; v < NV; v++) begin
            raw_in = vecs[v].raw;
            tick(1);
            $display("vec %0d raw=%h levels=%h edge=%h wake=%h wake_fd=%h",
                     v, raw_in, levels, edge_pulse, wake_sources, wake_fd);
            chk("vec_levels", levels, vecs[v].lv);
            chk("vec_edge", edge_pulse, vecs[v].ep);
            chk("vec_wake", wake_sources, vecs[v].wk);
            chk("vec_wake_fd", wake_fd, vecs[v].wk);
        end

        // Channel 1 rise then fall; on dut_fd only the falling edge sets the flag.
        raw_in = 8'h03;
        tick(10);
        $display("ch1 rise: levels_fd=%h wake_fd=%h wake=%h", levels_fd, wake_fd, wake_sources);
        chk("ch1_rise_levels", levels_fd, 8'h03);
        chk("ch1_rise_wake_fd", wake_fd, 8'h01);
        chk("ch1_rise_wake", wake_sources, 8'h03);
        raw_in = 8'h01;
        tick(5);
        chk("ch1_fall_pending", levels_fd, 8'h03);
        chk("ch1_fall_pending_wake", wake_fd, 8'h01);
        tick(1);
        $display("ch1 fall: levels_fd=%h edge_fd=%h wake_fd=%h", levels_fd, edge_fd, wake_fd);
        chk("ch1_fall_levels", levels_fd, 8'h01);
        chk("ch1_fall_edge", edge_fd, 8'h02);
        chk("ch1_fall_wake_fd", wake_fd, 8'h03);
        tick(4);

        // Halt for 5 cycles; flags hold, then clear on the edge halted is seen low.
        halted = 1'b1;
        tick(5);
        chk("halt_hold_wake", wake_sources, 8'h03);
        halted = 1'b0;
        tick(1);
        $display("halt exit: wake=%h wake_fd=%h", wake_sources, wake_fd);
        chk("halt_clear_wake", wake_sources, 8'h00);
        chk("halt_clear_wake_fd", wake_fd, 8'h00);

        // Flag set while running persists (FSM back in ARMED).
        raw_in = 8'h05;
        tick(6);
        chk("run_set_levels", levels, 8'h05);
        chk("run_set_wake", wake_sources, 8'h04);
        tick(3);
        chk("run_persist_wake", wake_sources, 8'h04);

        // Channel 3 accepted on the same edge the core leaves halt: set beats clear.
        raw_in = 8'h0D;
        halted = 1'b1;
        tick(5);
        chk("coinc_pre_wake", wake_sources, 8'h04);
        chk("coinc_pre_levels", levels, 8'h05);
        halted = 1'b0;
        tick(1);
        $display("coincident: levels=%h edge=%h wake=%h", levels, edge_pulse, wake_sources);
        chk("coinc_levels", levels, 8'h0D);
        chk("coinc_edge", edge_pulse, 8'h08);
        chk("coinc_wake", wake_sources, 8'h08);
        chk("coinc_wake_fd", wake_fd, 8'h08);

        // Asynchronous reset mid-count.
        raw_in = 8'hFF;
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        $display("async reset: levels=%h edge=%h wake=%h", levels, edge_pulse, wake_sources);
        chk("areset_levels", levels, 8'h00);
        chk("areset_wake", wake_sources, 8'h00);
        chk("areset_edge", edge_pulse, 8'h00);
        tick(2);
        reset = 1'b0;
        tick(D + 1);
        chk("post_reset_pending", levels, 8'h00);
        tick(1);
        $display("post reset: levels=%h edge=%h wake=%h wake_fd=%h",
                 levels, edge_pulse, wake_sources, wake_fd);
        chk("post_reset_levels", levels, 8'hFF);
        chk("post_reset_edge", edge_pulse, 8'hFF);
        chk("post_reset_wake", wake_sources, 8'hFF);
        chk("post_reset_wake_fd", wake_fd, 8'hFD);
        tick(1);
        chk("post_reset_edge_drop", edge_pulse, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
